// File: rtl/snake_body_engine.sv
// Multi-segment snake engine: body cells live in a ring buffer, an FSM moves the
// head, checks wall/food/self collisions and plots erased/drawn cells to the VGA.
module snake_body_engine #(
  parameter int CELL_XW  = 6,
  parameter int CELL_YW  = 5,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int BLK_LOG2 = 2,
  parameter int MAX_LEN  = 16,
  parameter int START_X  = 20,
  parameter int START_Y  = 15,
  parameter int WRAP     = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     tick,
  input  logic                     left,
  input  logic                     right,
  input  logic                     up,
  input  logic                     down,
  input  logic [2:0]               colour,
  input  logic [CELL_XW-1:0]       food_x,
  input  logic [CELL_YW-1:0]       food_y,
  input  logic                     food_valid,
  output logic [7:0]               x_out,
  output logic [6:0]               y_out,
  output logic [2:0]               c_out,
  output logic                     plot,
  output logic                     busy,
  output logic                     eaten,
  output logic                     dead,
  output logic [$clog2(MAX_LEN):0] length
);
  localparam int IW = $clog2(MAX_LEN);
  localparam int LW = IW + 1;
  localparam int KW = 2 * BLK_LOG2;
  localparam int SW = CELL_XW + CELL_YW;
  localparam logic [CELL_XW-1:0] X_LAST  = CELL_XW'(GRID_W - 1);
  localparam logic [CELL_YW-1:0] Y_LAST  = CELL_YW'(GRID_H - 1);
  localparam logic [CELL_XW-1:0] X_START = CELL_XW'(START_X);
  localparam logic [CELL_YW-1:0] Y_START = CELL_YW'(START_Y);

  localparam logic [1:0] D_RIGHT = 2'd0;
  localparam logic [1:0] D_LEFT  = 2'd1;
  localparam logic [1:0] D_UP    = 2'd2;
  localparam logic [1:0] D_DOWN  = 2'd3;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_CALC, S_SCAN, S_ERASE, S_DRAW, S_DEAD
  } state_t;

  state_t               state_reg;
  logic [KW-1:0]        k_reg;
  logic [IW-1:0]        ptr_reg;
  logic [LW-1:0]        len_reg;
  logic [IW-1:0]        scan_addr_reg;
  logic [LW-1:0]        scan_cnt_reg;
  logic [CELL_XW-1:0]   head_x_reg, new_x_reg, tail_x_reg;
  logic [CELL_YW-1:0]   head_y_reg, new_y_reg, tail_y_reg;
  logic [1:0]           dir_reg, pend_reg;
  logic                 grow_reg, hit_reg;

  logic                 req_valid;
  logic [1:0]           req_dir, ref_dir;
  logic [CELL_XW-1:0]   step_x;
  logic [CELL_YW-1:0]   step_y;
  logic                 off_grid, kill, food_hit;
  logic [IW-1:0]        tail_idx, rd_addr, mem_waddr;
  logic                 mem_we;
  logic [SW-1:0]        mem_wdata, rd_data;
  logic                 seg_match, hit_now;

  logic [SW-1:0] seg_mem [MAX_LEN];

  function automatic logic [7:0] pix_x(input logic [CELL_XW-1:0] cx, input logic [KW-1:0] k);
    pix_x = 8'({cx, k[BLK_LOG2-1:0]});
  endfunction

  function automatic logic [6:0] pix_y(input logic [CELL_YW-1:0] cy, input logic [KW-1:0] k);
    pix_y = 7'({cy, k[KW-1:BLK_LOG2]});
  endfunction

  // Reversal guard compares against the direction in force after this cycle,
  // so a key arriving during CALC cannot sneak in a reversal.
  always_comb begin
    req_valid = left | right | up | down;
    req_dir   = D_DOWN;
    if (left)       req_dir = D_LEFT;
    else if (right) req_dir = D_RIGHT;
    else if (up)    req_dir = D_UP;
    ref_dir = (state_reg == S_CALC) ? pend_reg : dir_reg;
  end

  always_comb begin
    step_x   = head_x_reg;
    step_y   = head_y_reg;
    off_grid = 1'b0;
    case (pend_reg)
      D_RIGHT: if (head_x_reg == X_LAST) begin step_x = '0; off_grid = 1'b1; end
               else step_x = head_x_reg + CELL_XW'(1);
      D_LEFT:  if (head_x_reg == '0) begin step_x = X_LAST; off_grid = 1'b1; end
               else step_x = head_x_reg - CELL_XW'(1);
      D_UP:    if (head_y_reg == '0) begin step_y = Y_LAST; off_grid = 1'b1; end
               else step_y = head_y_reg - CELL_YW'(1);
      default: if (head_y_reg == Y_LAST) begin step_y = '0; off_grid = 1'b1; end
               else step_y = head_y_reg + CELL_YW'(1);
    endcase
    kill     = off_grid && (WRAP == 0);
    food_hit = food_valid && !kill && (step_x == food_x) && (step_y == food_y);
  end

  // Scan walks from the tail towards the head; read address is issued one cycle early.
  always_comb begin
    tail_idx  = ptr_reg + IW'(1) - len_reg[IW-1:0];
    rd_addr   = (state_reg == S_CALC) ? tail_idx : scan_addr_reg;
    mem_we    = resetn && ((state_reg == S_INIT) || (state_reg == S_DRAW && k_reg == '0));
    mem_waddr = (state_reg == S_INIT) ? '0 : ptr_reg + IW'(1);
    mem_wdata = (state_reg == S_INIT) ? {X_START, Y_START} : {new_x_reg, new_y_reg};
    seg_match = (rd_data == {new_x_reg, new_y_reg});
    hit_now   = seg_match && !(scan_cnt_reg == '0 && !grow_reg);
  end

  always_ff @(posedge clk) begin
    if (mem_we) seg_mem[mem_waddr] <= mem_wdata;
    rd_data <= seg_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= S_INIT;
      k_reg         <= '0;
      ptr_reg       <= '0;
      len_reg       <= LW'(1);
      scan_addr_reg <= '0;
      scan_cnt_reg  <= '0;
      head_x_reg    <= X_START;
      head_y_reg    <= Y_START;
      new_x_reg     <= X_START;
      new_y_reg     <= Y_START;
      tail_x_reg    <= X_START;
      tail_y_reg    <= Y_START;
      dir_reg       <= D_RIGHT;
      pend_reg      <= D_RIGHT;
      grow_reg      <= 1'b0;
      hit_reg       <= 1'b0;
      plot          <= 1'b0;
      eaten         <= 1'b0;
      dead          <= 1'b0;
      x_out         <= '0;
      y_out         <= '0;
      c_out         <= '0;
    end else begin
      plot  <= 1'b0;
      eaten <= 1'b0;
      if (req_valid && req_dir != (ref_dir ^ 2'b01)) pend_reg <= req_dir;
      case (state_reg)
        S_INIT: begin
          plot  <= 1'b1;
          x_out <= pix_x(head_x_reg, k_reg);
          y_out <= pix_y(head_y_reg, k_reg);
          c_out <= colour;
          k_reg <= k_reg + KW'(1);
          if (k_reg == '1) state_reg <= S_IDLE;
        end
        S_IDLE: if (tick) state_reg <= S_CALC;
        S_CALC: begin
          dir_reg       <= pend_reg;
          new_x_reg     <= step_x;
          new_y_reg     <= step_y;
          grow_reg      <= food_hit && (len_reg < LW'(MAX_LEN));
          eaten         <= food_hit;
          hit_reg       <= 1'b0;
          scan_cnt_reg  <= '0;
          scan_addr_reg <= tail_idx + IW'(1);
          if (kill) begin
            state_reg <= S_DEAD;
            dead      <= 1'b1;
          end else begin
            state_reg <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (scan_cnt_reg == '0) {tail_x_reg, tail_y_reg} <= rd_data;
          if (hit_now) hit_reg <= 1'b1;
          scan_cnt_reg  <= scan_cnt_reg + LW'(1);
          scan_addr_reg <= scan_addr_reg + IW'(1);
          k_reg         <= '0;
          if (scan_cnt_reg == len_reg - LW'(1)) begin
            if (hit_reg || hit_now) begin
              state_reg <= S_DEAD;
              dead      <= 1'b1;
            end else if (grow_reg) begin
              state_reg <= S_DRAW;
            end else begin
              state_reg <= S_ERASE;
            end
          end
        end
        S_ERASE: begin
          plot  <= 1'b1;
          x_out <= pix_x(tail_x_reg, k_reg);
          y_out <= pix_y(tail_y_reg, k_reg);
          c_out <= 3'b000;
          k_reg <= k_reg + KW'(1);
          if (k_reg == '1) state_reg <= S_DRAW;
        end
        S_DRAW: begin
          plot  <= 1'b1;
          x_out <= pix_x(new_x_reg, k_reg);
          y_out <= pix_y(new_y_reg, k_reg);
          c_out <= colour;
          k_reg <= k_reg + KW'(1);
          if (k_reg == '0) begin
            head_x_reg <= new_x_reg;
            head_y_reg <= new_y_reg;
            ptr_reg    <= ptr_reg + IW'(1);
            len_reg    <= len_reg + LW'(grow_reg);
          end
          if (k_reg == '1) state_reg <= S_IDLE;
        end
        default: state_reg <= S_DEAD;
      endcase
    end
  end

  assign busy   = (state_reg != S_IDLE) && (state_reg != S_DEAD);
  assign length = len_reg;

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: a WRAP=0 and a WRAP=1 instance share stimulus;
// expected pixel writes are queued per instance and popped as the DUTs plot.
module tb_snake_body_engine;
  logic       clk = 1'b0;
  logic       resetn, tick, left, right, up, down, food_valid;
  logic [2:0] colour;
  logic [5:0] food_x;
  logic [4:0] food_y;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic [2:0] c0, c1;
  logic       plot0, plot1, busy0, busy1, eaten0, eaten1, dead0, dead1;
  logic [4:0] length0, length1;

  int checks = 0;
  int errors = 0;
  int eaten_cnt = 0;
  int lat;
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [17:0] exp0, exp1;

  always #5 clk = ~clk;

  snake_body_engine #(.WRAP(0)) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .left(left), .right(right), .up(up), .down(down),
    .colour(colour), .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .x_out(x0), .y_out(y0), .c_out(c0), .plot(plot0), .busy(busy0), .eaten(eaten0),
    .dead(dead0), .length(length0)
  );

  snake_body_engine #(.WRAP(1)) dut_wrap (
    .clk(clk), .resetn(resetn), .tick(tick), .left(left), .right(right), .up(up), .down(down),
    .colour(colour), .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .x_out(x1), .y_out(y1), .c_out(c1), .plot(plot1), .busy(busy1), .eaten(eaten1),
    .dead(dead1), .length(length1)
  );

  always @(negedge clk) begin
    if (plot0 === 1'b1) begin
      checks++;
      assert (q0.size() > 0) else begin
        errors++;
        $error("FAIL plot_extra0: observed x=%0d y=%0d c=%0d expected no plot", x0, y0, c0);
      end
      if (q0.size() > 0) begin
        exp0 = q0.pop_front();
        checks++;
        assert ({x0, y0, c0} === exp0) else begin
          errors++;
          $error("FAIL pixel0: observed x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                 x0, y0, c0, exp0[17:10], exp0[9:3], exp0[2:0]);
        end
      end
    end
    if (plot1 === 1'b1) begin
      checks++;
      assert (q1.size() > 0) else begin
        errors++;
        $error("FAIL plot_extra1: observed x=%0d y=%0d c=%0d expected no plot", x1, y1, c1);
      end
      if (q1.size() > 0) begin
        exp1 = q1.pop_front();
        checks++;
        assert ({x1, y1, c1} === exp1) else begin
          errors++;
          $error("FAIL pixel1: observed x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                 x1, y1, c1, exp1[17:10], exp1[9:3], exp1[2:0]);
        end
      end
    end
    if (eaten0 === 1'b1) eaten_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
    $display("check %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic push_cell(input int cx, input int cy, input int c, input bit to0, input bit to1);
    for (int k = 0; k < 16; k++) begin
      logic [17:0] e;
      e = {8'(cx * 4 + k % 4), 7'(cy * 4 + k / 4), 3'(c)};
      if (to0) q0.push_back(e);
      if (to1) q1.push_back(e);
    end
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while ((busy0 === 1'b1 || busy1 === 1'b1) && cycles < 300) begin
      cycles++;
      @(negedge clk);
    end
    checks++;
    assert (cycles < 300) else begin
      errors++;
      $error("FAIL idle_timeout: observed %0d cycles expected < 300", cycles);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic move(output int cycles);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    wait_idle(cycles);
  endtask

  task automatic press(input int which);
    @(negedge clk);
    left  = (which == 0);
    right = (which == 1);
    up    = (which == 2);
    down  = (which == 3);
    @(negedge clk);
    {left, right, up, down} = 4'b0000;
  endtask

  initial begin
    resetn = 1'b0; tick = 1'b0; {left, right, up, down} = 4'b0000;
    colour = 3'b101; food_x = '0; food_y = '0; food_valid = 1'b0;

    // Reset values, then a reset that lands in the middle of INIT plotting.
    repeat (3) @(negedge clk);
    check("rst_plot", plot0, 0);
    check("rst_busy", busy0, 1);
    check("rst_dead", dead0, 0);
    check("rst_eaten", eaten0, 0);
    check("rst_length", length0, 1);
    push_cell(20, 15, 5, 1, 1);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midreset_plot", plot0, 0);
    check("midreset_busy", busy0, 1);
    q0.delete(); q1.delete();
    push_cell(20, 15, 5, 1, 1);
    resetn = 1'b1;
    wait_idle(lat);
    check("init_q_empty", q0.size(), 0);
    check("init_length", length0, 1);
    check("init_busy", busy0, 0);

    // Plain move right.
    push_cell(20, 15, 0, 1, 1);
    push_cell(21, 15, 5, 1, 1);
    move(lat);
    check("plain_latency", lat, 34);
    check("plain_q_empty", q0.size(), 0);
    check("plain_length", length0, 1);

    // Eat food: no erase, length grows.
    food_x = 6'd22; food_y = 5'd15; food_valid = 1'b1;
    eaten_cnt = 0;
    push_cell(22, 15, 5, 1, 1);
    move(lat);
    food_valid = 1'b0;
    check("grow_latency", lat, 18);
    check("grow_eaten_pulses", eaten_cnt, 1);
    check("grow_length", length0, 2);
    check("grow_q_empty", q0.size(), 0);

    // Reversal request is ignored.
    press(0);
    push_cell(21, 15, 0, 1, 1);
    push_cell(23, 15, 5, 1, 1);
    move(lat);
    check("reverse_latency", lat, 35);
    check("reverse_q_empty", q0.size(), 0);

    // Grow to five segments.
    eaten_cnt = 0;
    for (int fx = 24; fx <= 26; fx++) begin
      food_x = 6'(fx); food_valid = 1'b1;
      push_cell(fx, 15, 5, 1, 1);
      move(lat);
      food_valid = 1'b0;
      check("grow5_latency", lat, 1 + (fx - 22) + 16);
    end
    check("grow5_length", length0, 5);
    check("grow5_eaten_pulses", eaten_cnt, 3);
    check("grow5_q_empty", q0.size(), 0);

    // Down, left, up: head runs into its own body.
    press(3);
    push_cell(22, 15, 0, 1, 1);
    push_cell(26, 16, 5, 1, 1);
    move(lat);
    check("down_latency", lat, 38);
    press(0);
    push_cell(23, 15, 0, 1, 1);
    push_cell(25, 16, 5, 1, 1);
    move(lat);
    press(2);
    move(lat);
    check("self_dead", dead0, 1);
    check("self_busy", busy0, 0);
    check("self_dead_wrap", dead1, 1);
    check("self_q_empty", q0.size() + q1.size(), 0);
    check("self_length", length0, 5);

    // Fresh game, run to the right edge.
    @(negedge clk) resetn = 1'b0;
    repeat (2) @(negedge clk);
    q0.delete(); q1.delete();
    push_cell(20, 15, 5, 1, 1);
    resetn = 1'b1;
    wait_idle(lat);
    check("rst2_dead", dead0, 0);
    for (int hx = 21; hx <= 39; hx++) begin
      push_cell(hx - 1, 15, 0, 1, 1);
      push_cell(hx, 15, 5, 1, 1);
      move(lat);
    end
    check("edge_q_empty", q0.size() + q1.size(), 0);
    check("edge_alive", dead0, 0);
    push_cell(39, 15, 0, 0, 1);
    push_cell(0, 15, 5, 0, 1);
    move(lat);
    check("wall_dead", dead0, 1);
    check("wall_busy", busy0, 0);
    check("wrap_alive", dead1, 0);
    check("wrap_busy", busy1, 0);
    check("wrap_q_empty", q1.size(), 0);
    check("wrap_length", length1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
